packet_tx_sched: RTL and testbench
==================================

PACKET_TX_SCHED -- requirements
Module: packet_tx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, meaning bits per frame row.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, meaning rows in a 64-bit cluster frame.
REQ-003 SHALL have port clk  input  1  single block clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports enc0_req / enc1_req  input  1 each  64-bit / 16-bit cluster frame ready, held until granted.
REQ-006 SHALL have ports enc0_gnt / enc1_gnt  output  1 each  one-cycle grant pulse; requester drops req next cycle.
REQ-007 SHALL have port enc_used  output  1  frame format select to scrambler (0=64-bit, 1=16-bit).
REQ-008 SHALL have port par_in  input  DATA_DEPTH x DATA_WIDTH  scrambled frame from scrambler.
REQ-009 SHALL have port err_inj_arm  input  1  pulse arming one-shot error injection.
REQ-010 SHALL have port err_inj_enable  output  1  injection enable to scrambler.
REQ-011 SHALL have ports row_data  output  DATA_WIDTH, row_valid  output  1, row_ready  input  1, row_last  output  1  row stream to serializer.
REQ-012 SHALL have ports busy  output  1, frame_done  output  1 (pulse), tx_frame_cnt  output  16.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SEND -> IDLE.
REQ-014 IDLE: on any req, SHALL select winner via round-robin, register enc_used, go LOAD next cycle.
REQ-015 Both reqs same cycle SHALL grant the cluster not granted last; single req SHALL always win.
REQ-016 LOAD (exactly one cycle): SHALL pulse winner's gnt, capture par_in into frame buffer at cycle end, enc_used stable throughout.
REQ-017 SEND: row_valid SHALL be high from first cycle, row 0 first, row index +1 per cycle with row_valid and row_ready both high.
REQ-018 Row count SHALL be DATA_DEPTH for enc_used=0, 4 for enc_used=1; row_last high only with final row.
REQ-019 row_data/row_last SHALL hold stable while row_valid and not row_ready.
REQ-020 On final-row transfer SHALL pulse frame_done, increment tx_frame_cnt (wraps 0xFFFF->0), return IDLE; next grant no earlier than one IDLE cycle later.
REQ-021 busy SHALL be high in LOAD and SEND; reqs outside IDLE SHALL be ignored until IDLE.
REQ-022 enc_used SHALL retain last value in IDLE (no scrambler glitch).

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, gnts 0, enc_used 0, row_valid 0, row_last 0, row_data 0, busy 0, frame_done 0, err_inj_enable 0, armed flag 0, tx_frame_cnt 0, frame buffer 0, round-robin pointer "enc1 last" (enc0 wins first tie).
REQ-024 Reset mid-SEND SHALL abandon the frame without frame_done; no partial resume.

Configuration
REQ-025 With ERR_INJ_EN defined: err_inj_arm SHALL set an armed flag; err_inj_enable SHALL be high exactly during the LOAD cycle of the next enc0 frame, then armed clears; enc1 frames leave armed unchanged; arm while armed no effect; arm coinciding with the LOAD cycle applies to the following enc0 frame.
REQ-026 Without ERR_INJ_EN: err_inj_enable SHALL be constant 0, err_inj_arm ignored, no armed flag logic.

Structure
REQ-027 fec_pkg SHALL hold the FSM state typedef and constants FRAME0_ROWS=8, FRAME1_ROWS=4.
REQ-028 Two-requester round-robin SHALL be sub-module tx_rr_arb (req[1:0], advance, gnt onehot, last-grant pointer).

Verification
REQ-029 enc0_req alone, row_ready=1 -> gnt0 one cycle after req, 8 rows row0..row7 consecutive, row_last on row 7, frame_done, tx_frame_cnt=1.
REQ-030 enc1_req alone, par_in rows 0..3 = 0x001,0x002,0x004,0x008 -> 4 rows in that order, row_last on 0x008, enc_used=1 through SEND.
REQ-031 enc0_req and enc1_req held together for 3 frames -> grants enc0, enc1, enc0.
REQ-032 row_ready toggled 1,0,0,1 during SEND -> row_data unchanged during stall, no row dropped/duplicated.
REQ-033 ERR_INJ_EN: arm then enc1 frame then enc0 frame -> err_inj_enable 0 for enc1, one-cycle high in enc0 LOAD, 0 after.
REQ-034 rst_n low during row 3 of enc0 frame -> all outputs reset immediately, no frame_done, tx_frame_cnt=0; next enc1_req served normally.

Source files
------------

// File: rtl/fec_pkg.sv
// fec_pkg: shared FSM state type and frame row counts for the packet TX scheduler.
package fec_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} tx_state_t;
  localparam int FRAME0_ROWS = 8;
  localparam int FRAME1_ROWS = 4;
endpackage

// File: rtl/tx_rr_arb.sv
// tx_rr_arb: two-requester round-robin arbiter; a tie goes to the requester not granted last.
module tx_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last
);
  // last = 1 means requester 1 was granted most recently
  always_comb gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (advance) last <= gnt[1];
endmodule

// File: rtl/packet_tx_sched.sv
// packet_tx_sched: grants one of two encoders, loads its scrambled frame and streams it row by row.
// Optional one-shot error injection on the next enc0 frame is built when ERR_INJ_EN is defined.
module packet_tx_sched
  import fec_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DATA_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enc0_req,
  input  logic                                 enc1_req,
  output logic                                 enc0_gnt,
  output logic                                 enc1_gnt,
  output logic                                 enc_used,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
  input  logic                                 err_inj_arm,
  output logic                                 err_inj_enable,
  output logic [DATA_WIDTH-1:0]                row_data,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic                                 row_last,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [15:0]                          tx_frame_cnt
);
  localparam int IW = $clog2(DATA_DEPTH);
  tx_state_t state;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] fbuf;
  logic [IW-1:0] idx, nxt_idx, last_idx;
  logic [1:0] arb_gnt;
  logic unused_rr_last;
  logic start;
  assign start    = (state == S_IDLE) && (enc0_req || enc1_req);
  assign nxt_idx  = idx + 1'b1;
  assign last_idx = enc_used ? IW'(FRAME1_ROWS - 1) : IW'(DATA_DEPTH - 1);
  tx_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({enc1_req, enc0_req}),
    .advance(start),
    .gnt    (arb_gnt),
    .last   (unused_rr_last)
  );
`ifdef ERR_INJ_EN
  logic armed;
  // an arm landing in the LOAD cycle that consumes the flag re-arms for the following enc0 frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed          <= 1'b0;
      err_inj_enable <= 1'b0;
    end else begin
      armed          <= err_inj_arm | (armed & ~((state == S_LOAD) & err_inj_enable));
      err_inj_enable <= start & arb_gnt[0] & armed;
    end
`else
  logic unused_arm;
  assign unused_arm     = err_inj_arm;
  assign err_inj_enable = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      enc0_gnt     <= 1'b0;
      enc1_gnt     <= 1'b0;
      enc_used     <= 1'b0;
      row_valid    <= 1'b0;
      row_last     <= 1'b0;
      row_data     <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      tx_frame_cnt <= '0;
      fbuf         <= '0;
      idx          <= '0;
    end else begin
      enc0_gnt   <= 1'b0;
      enc1_gnt   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          enc0_gnt <= arb_gnt[0];
          enc1_gnt <= arb_gnt[1];
          enc_used <= arb_gnt[1];
          busy     <= 1'b1;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          fbuf      <= par_in;
          row_data  <= par_in[0];
          row_valid <= 1'b1;
          row_last  <= 1'b0;
          idx       <= '0;
          state     <= S_SEND;
        end
        S_SEND: if (row_ready) begin
          if (idx == last_idx) begin
            row_valid    <= 1'b0;
            row_last     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b1;
            tx_frame_cnt <= tx_frame_cnt + 1'b1;
            state        <= S_IDLE;
          end else begin
            idx      <= nxt_idx;
            row_data <= fbuf[nxt_idx];
            row_last <= (nxt_idx == last_idx);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_packet_tx_sched.sv
// tb_packet_tx_sched: directed table plus randomized frames checked against a transaction-level model.
module tb_packet_tx_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enc0_req = 1'b0, enc1_req = 1'b0, err_inj_arm = 1'b0, row_ready = 1'b0;
  logic [7:0][9:0] par_in = '0;
  logic enc0_gnt, enc1_gnt, enc_used, err_inj_enable, row_valid, row_last, busy, frame_done;
  logic [9:0] row_data;
  logic [15:0] tx_frame_cnt;
  int checks = 0, errors = 0;
  bit mlast = 1'b1, marmed = 1'b0;
  logic [15:0] mcnt = '0;
  typedef struct { bit r0; bit r1; bit [3:0] rpat; bit exp_w; } vec_t;
  vec_t vt [6];
  logic [7:0][9:0] pp;
  packet_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .enc0_req(enc0_req), .enc1_req(enc1_req),
    .enc0_gnt(enc0_gnt), .enc1_gnt(enc1_gnt), .enc_used(enc_used), .par_in(par_in),
    .err_inj_arm(err_inj_arm), .err_inj_enable(err_inj_enable), .row_data(row_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_last(row_last), .busy(busy),
    .frame_done(frame_done), .tx_frame_cnt(tx_frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit pick(input bit p0, input bit p1);
    return (p0 && p1) ? !mlast : p1;
  endfunction
  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_gnt"}, {enc0_gnt, enc1_gnt}, 0);
    chk({tag, "_enc_used"}, enc_used, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_row_last"}, row_last, 0);
    chk({tag, "_row_data"}, row_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_inj"}, err_inj_enable, 0);
    chk({tag, "_cnt"}, tx_frame_cnt, 0);
  endtask
  task automatic pulse_arm();
    err_inj_arm = 1'b1;
    @(negedge clk);
    err_inj_arm = 1'b0;
    marmed = 1'b1;
  endtask
  task automatic frame(input bit r0, input bit r1, input logic [7:0][9:0] par, input bit [3:0] rpat,
                       input bit use_pat, input int abort_at, input bit arm_at_load, input bit w);
    int n, k, cyc;
    bit exp_en;
    enc0_req = enc0_req | r0;
    enc1_req = enc1_req | r1;
    par_in = par;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", {enc0_gnt, enc1_gnt}, 0);
    @(negedge clk);
`ifdef ERR_INJ_EN
    exp_en = !w && marmed;
`else
    exp_en = 1'b0;
`endif
    chk("load_gnt0", enc0_gnt, !w);
    chk("load_gnt1", enc1_gnt, w);
    chk("load_enc_used", enc_used, w);
    chk("load_busy", busy, 1);
    chk("load_row_valid", row_valid, 0);
    chk("load_err_inj", err_inj_enable, exp_en);
    if (!w) marmed = 1'b0;
    if (arm_at_load) begin
      err_inj_arm = 1'b1;
      marmed = 1'b1;
    end
    mlast = w;
    if (w) enc1_req = 1'b0; else enc0_req = 1'b0;
    n = w ? 4 : 8;
    k = 0;
    cyc = 0;
    @(negedge clk);
    err_inj_arm = 1'b0;
    while (k < n && cyc < 200) begin
      chk("row_valid", row_valid, 1);
      chk("row_data", row_data, par[k]);
      chk("row_last", row_last, k == n - 1);
      chk("send_enc_used", enc_used, w);
      chk("send_busy", busy, 1);
      chk("send_frame_done", frame_done, 0);
      chk("send_err_inj", err_inj_enable, 0);
      chk("send_gnt", {enc0_gnt, enc1_gnt}, 0);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 reset_outputs_chk("abort");
        enc0_req = 1'b0;
        enc1_req = 1'b0;
        @(negedge clk);
        chk("abort_no_done", frame_done, 0);
        rst_n = 1'b1;
        mcnt = '0;
        mlast = 1'b1;
        marmed = 1'b0;
        return;
      end
      row_ready = use_pat ? rpat[cyc % 4] : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (row_ready) k++;
      cyc++;
    end
    if (k < n) chk("row_timeout", k, n);
    mcnt++;
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("done_row_valid", row_valid, 0);
    chk("done_row_last", row_last, 0);
    chk("done_cnt", tx_frame_cnt, mcnt);
    chk("done_enc_used_hold", enc_used, w);
  endtask
  initial begin
    vt[0] = '{1'b1, 1'b0, 4'hF, 1'b0};
    vt[1] = '{1'b0, 1'b1, 4'hF, 1'b1};
    vt[2] = '{1'b1, 1'b1, 4'hF, 1'b0};
    vt[3] = '{1'b1, 1'b1, 4'hF, 1'b1};
    vt[4] = '{1'b1, 1'b1, 4'b1001, 1'b0};
    vt[5] = '{1'b0, 1'b0, 4'b1001, 1'b1};
    for (int i = 0; i < 8; i++) pp[i] = 10'(1 << i);
    #3 reset_outputs_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      frame(vt[i].r0, vt[i].r1, pp, vt[i].rpat, 1'b1, -1, 1'b0, vt[i].exp_w);
    pulse_arm();
    frame(1'b0, 1'b1, pp, 4'hF, 1'b1, -1, 1'b0, 1'b1);
    frame(1'b1, 1'b0, pp, 4'hF, 1'b1, -1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, pp, 4'hF, 1'b1, -1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, pp, 4'hF, 1'b1, -1, 1'b1, 1'b0);
    frame(1'b0, 1'b1, pp, 4'hF, 1'b1, -1, 1'b0, 1'b1);
    frame(1'b1, 1'b0, pp, 4'hF, 1'b1, -1, 1'b0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      int r;
      bit w;
      if (!enc0_req && !enc1_req) begin
        if ($urandom_range(0, 3) == 0) pulse_arm();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      r = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) pp[i] = 10'($urandom);
      w = pick(enc0_req | r[0], enc1_req | r[1]);
      frame(r[0], r[1], pp, 4'h0, 1'b0, -1, $urandom_range(0, 7) == 0, w);
    end
    while (enc0_req || enc1_req)
      frame(1'b0, 1'b0, pp, 4'hF, 1'b1, -1, 1'b0, pick(enc0_req, enc1_req));
    frame(1'b1, 1'b0, pp, 4'hF, 1'b1, 3, 1'b0, 1'b0);
    frame(1'b0, 1'b1, pp, 4'hF, 1'b1, -1, 1'b0, 1'b1);
    chk("post_reset_cnt", tx_frame_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
